ibex_fetch_req_initiator: RTL

// - Initiator side of the instruction-memory bus: issues word-aligned fetch requests and tracks
//   up to NUM_REQS in-flight responses.
// - Discards responses belonging to fetches killed by a branch.
// - Writes surviving responses into the fetch FIFO input port, and drives its clear/address.
// - Sits between the IF-stage controller and the fetch FIFO.

---
 rtl/ibex_pkg.sv | 28 ++
 rtl/ibex_fetch_rsp_tracker.sv | 103 ++++++++++
 rtl/ibex_fetch_req_initiator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// ============================================================================
// Module      : ibex_pkg
// Description : Shared types and helpers for the instruction-fetch request
//               initiator and its response-slot tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_pkg;

    // Fetch request FSM. WAIT_GNT holds a request that the bus has not yet
    // accepted, so its address must stay frozen.
    typedef enum logic [0:0] {
        FETCH_IDLE     = 1'b0,
        FETCH_WAIT_GNT = 1'b1
    } fetch_req_state_e;

    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;
    localparam logic [31:0] c_word_step = 32'd4;

    // Drop the halfword offset. The bus only accepts word addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & c_word_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_fetch_rsp_tracker.sv
// ============================================================================
// Module      : ibex_fetch_rsp_tracker
// Description : In-order tracker for granted fetch requests awaiting rvalid.
//               Slot 0 is always the oldest. Each slot carries an outstanding
//               bit and a discard bit.
// Ports       : clk_i, rst_ni      clock, async active-low reset
//               push_i             a request is granted this cycle
//               push_discard_i     discard bit for the slot being filled
//               pop_i              a response returns this cycle (slot 0)
//               kill_i             branch: mark every occupied slot discarded
//               head_valid_o       slot 0 outstanding
//               head_discard_o     slot 0 response must be dropped
//               slots_used_o       number of occupied slots
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_fetch_rsp_tracker
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2,
    localparam int unsigned CNT_W   = $clog2(NUM_REQS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             push_discard_i,
    input  logic             pop_i,
    input  logic             kill_i,
    output logic             head_valid_o,
    output logic             head_discard_o,
    output logic [CNT_W-1:0] slots_used_o
);

    localparam logic [CNT_W-1:0] c_max_used = CNT_W'(NUM_REQS);

    logic [NUM_REQS-1:0] r_outstanding;
    logic [NUM_REQS-1:0] r_discard;

    logic [NUM_REQS:0]   w_out_ext;
    logic [NUM_REQS:0]   w_disc_ext;
    logic [NUM_REQS-1:0] w_out_shift;
    logic [NUM_REQS-1:0] w_disc_shift;
    logic [NUM_REQS-1:0] w_out_next;
    logic [NUM_REQS-1:0] w_disc_next;
    logic                w_filled;
    logic [CNT_W-1:0]    w_used;

    // A zero above the top slot is what shifts in on a pop.
    assign w_out_ext  = {1'b0, r_outstanding};
    assign w_disc_ext = {1'b0, r_discard};

    // Pop first, then fill the lowest free slot, so a same-cycle grant and
    // response leave the occupancy unchanged.
    always_comb begin
        w_out_shift  = pop_i ? w_out_ext[NUM_REQS:1]  : r_outstanding;
        w_disc_shift = pop_i ? w_disc_ext[NUM_REQS:1] : r_discard;
        w_out_next   = w_out_shift;
        w_disc_next  = w_disc_shift | (w_out_shift & {NUM_REQS{kill_i}});
        w_filled     = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (push_i && !w_filled && !w_out_shift[i]) begin
                w_out_next[i]  = 1'b1;
                w_disc_next[i] = push_discard_i;
                w_filled       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
        end
    end

    always_comb begin
        w_used = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_used = w_used + CNT_W'(r_outstanding[i]);
        end
    end

    assign head_valid_o   = r_outstanding[0];
    assign head_discard_o = r_discard[0];
    assign slots_used_o   = w_used;

    // A response with nothing outstanding is a bus protocol violation.
    a_rvalid_has_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_i |-> r_outstanding[0]);

    a_slots_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_used <= c_max_used);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_i |-> !w_out_shift[NUM_REQS-1]);

endmodule

`default_nettype wire

// File: rtl/ibex_fetch_req_initiator.sv
// ============================================================================
// Module      : ibex_fetch_req_initiator
// Description : Instruction-bus initiator. Issues word-aligned fetches, tracks
//               up to NUM_REQS granted-but-unanswered requests, drops
//               responses of fetches killed by a branch and writes surviving
//               responses into the fetch FIFO.
// Ports       : clk_i, rst_ni          clock, async active-low reset
//               req_i                  fetching enabled
//               branch_i, addr_i       one-cycle redirect and its target
//               busy_o                 request pending or responses outstanding
//               fifo_clear_o/addr_o    FIFO flush and restart address
//               fifo_valid_o/rdata_o/err_o  FIFO write port
//               fifo_ready_i           FIFO can absorb NUM_REQS more words
//               instr_req_o/gnt_i/addr_o    bus request channel
//               instr_rvalid_i/rdata_i/err_i bus response channel
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_fetch_req_initiator
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    input  logic        fifo_ready_i,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
    localparam logic [CNT_W-1:0] c_max_used = CNT_W'(NUM_REQS);

    fetch_req_state_e r_state;
    fetch_req_state_e w_state_next;

    logic [31:0] r_fetch_addr;    // next sequential fetch address
    logic [31:0] r_held_addr;     // address of the ungranted request
    logic [31:0] r_branch_addr;   // target of a branch taken during WAIT_GNT
    logic        r_branch_pend;   // r_branch_addr must be used next
    logic        r_held_kill;     // the held request belongs to a dead path

    logic [CNT_W-1:0] w_slots_used;
    logic             w_head_valid;
    logic             w_head_discard;
    logic             w_slot_free;
    logic             w_req_idle;
    logic [31:0]      w_idle_addr;
    logic             w_grant;
    logic             w_push_discard;

    // A response arriving this cycle frees slot 0 in time for a new grant.
    assign w_slot_free = (w_slots_used < c_max_used) | instr_rvalid_i;
    assign w_req_idle  = req_i & fifo_ready_i & w_slot_free;

    always_comb begin
        if (branch_i) begin
            w_idle_addr = word_align(addr_i);
        end else if (r_branch_pend) begin
            w_idle_addr = r_branch_addr;
        end else begin
            w_idle_addr = r_fetch_addr;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE: begin
                if (w_req_idle && !instr_gnt_i) begin
                    w_state_next = FETCH_WAIT_GNT;
                end
            end
            FETCH_WAIT_GNT: begin
                if (instr_gnt_i) begin
                    w_state_next = FETCH_IDLE;
                end
            end
            default: w_state_next = FETCH_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        instr_req_o  = w_req_idle;
        instr_addr_o = w_idle_addr;
        if (r_state == FETCH_WAIT_GNT) begin
            instr_req_o  = 1'b1;
            instr_addr_o = r_held_addr;
        end
    end

    assign w_grant = instr_req_o & instr_gnt_i;

    // In IDLE the request already carries the branch target, so only a held
    // WAIT_GNT request can be on a dead path when it is granted.
    assign w_push_discard = (r_state == FETCH_WAIT_GNT) & (branch_i | r_held_kill);

    // ---------------- Address bookkeeping ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_addr  <= '0;
            r_held_addr   <= '0;
            r_branch_addr <= '0;
            r_branch_pend <= 1'b0;
            r_held_kill   <= 1'b0;
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    r_held_kill <= 1'b0;
                    if (w_req_idle) begin
                        r_branch_pend <= 1'b0;
                        if (instr_gnt_i) begin
                            r_fetch_addr <= w_idle_addr + c_word_step;
                        end else begin
                            r_held_addr <= w_idle_addr;
                            if (branch_i) begin
                                r_fetch_addr <= word_align(addr_i);
                            end
                        end
                    end else if (branch_i) begin
                        r_fetch_addr  <= word_align(addr_i);
                        r_branch_pend <= 1'b0;
                    end
                end
                FETCH_WAIT_GNT: begin
                    if (instr_gnt_i) begin
                        r_fetch_addr <= r_held_addr + c_word_step;
                    end
                    if (branch_i) begin
                        r_branch_addr <= word_align(addr_i);
                        r_branch_pend <= 1'b1;
                    end
                    r_held_kill <= !instr_gnt_i && (r_held_kill || branch_i);
                end
                default: begin
                    r_held_kill <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- Response slots ----------------
    ibex_fetch_rsp_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_rsp_tracker (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .push_i         (w_grant),
        .push_discard_i (w_push_discard),
        .pop_i          (instr_rvalid_i),
        .kill_i         (branch_i),
        .head_valid_o   (w_head_valid),
        .head_discard_o (w_head_discard),
        .slots_used_o   (w_slots_used)
    );

    // ---------------- FIFO side ----------------
    assign fifo_valid_o = instr_rvalid_i & ~w_head_discard & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;

    assign busy_o = instr_req_o | w_head_valid;

    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

endmodule

`default_nettype wire
